mux_bus_arbiter: RTL
====================

Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares the 4-bit 2-to-1 mux datapath (F = S ? B : A) between two requesters, A and B.
- Owns the select line S and grants the bus to one requester at a time.
- Presents the selected data to a single downstream consumer through a valid/ready handshake.
- Bounds bus tenure with a beat budget so neither requester can starve the other.

Parameters:
- WIDTH, 4, data width of each requester and of the bus.
- HOLD_MAX, 3, maximum completed beats per grant while the other requester waits; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- req_a  input  1  requester A wants the bus.
- data_a  input  WIDTH  requester A data (mux input A).
- req_b  input  1  requester B wants the bus.
- data_b  input  WIDTH  requester B data (mux input B).
- bus_ready  input  1  consumer accepts the current beat.
- gnt_a  output  1  A owns the bus (registered).
- gnt_b  output  1  B owns the bus (registered).
- sel  output  1  mux select S: 0 = A, 1 = B (registered).
- bus_data  output  WIDTH  mux output F = sel ? data_b : data_a (combinational from sel).
- bus_valid  output  1  beat present: (gnt_a & req_a) | (gnt_b & req_b).

Behaviour:
- State: FSM {IDLE, GNT_A, GNT_B}, last-owner bit `last`, beat counter `cnt` of width $clog2(HOLD_MAX+1).
- Reset (rst_n = 0 at a rising edge), from any state including mid-transfer:
  - state = IDLE, gnt_a = gnt_b = 0, sel = 0, last = B (so A wins the first tie), cnt = 0.
  - bus_valid = 0 and bus_data = data_a while in reset.
- Outputs per state:
  - gnt_a = 1 exactly in GNT_A; gnt_b = 1 exactly in GNT_B.
  - sel = 1 in GNT_B, 0 in GNT_A; in IDLE sel keeps its previous value.
- Beat: one beat completes on a cycle with bus_valid & bus_ready. cnt increments on each beat and is cleared on every grant change.
- Grant latency: req asserted in cycle N from IDLE produces gnt in cycle N+1; no combinational req-to-gnt path.
- IDLE transitions:
  - Only req_a -> GNT_A. Only req_b -> GNT_B.
  - Both requesting -> grant the requester that is not `last`.
  - Neither -> stay in IDLE.
- GNT_A transitions (GNT_B is symmetric with A and B swapped):
  - req_a = 0: go to GNT_B if req_b = 1, else IDLE. This is a direct handover with no bubble cycle.
  - A beat completes with cnt+1 == HOLD_MAX and req_b = 1: go to GNT_B.
  - A beat completes with cnt+1 == HOLD_MAX and req_b = 0: stay in GNT_A, clear cnt.
  - Otherwise: stay in GNT_A.
- `last` updates to the outgoing owner on every GNT_x exit.
- Stalls: bus_ready = 0 freezes cnt and state unless the owner drops req. Dropping req aborts the pending beat with no transfer counted.
- Requester obligation: data_x must stay stable while bus_valid = 1 and bus_ready = 0. The arbiter does not latch data.
- Non-owner requests are only sampled at grant decisions. A pulse on req_b that falls before a decision point is lost.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises req: handover occurs.
  - The final budget beat and the owner dropping req in the same cycle: the same handover occurs, counted once.
- bus_valid is never asserted in IDLE. gnt_a & gnt_b is never 1.

Test Plan:
- Reset: hold rst_n = 0 for 2 clk with req_a = req_b = 1 -> gnt_a = gnt_b = 0, sel = 0, bus_valid = 0. First edge after release -> gnt_a = 1, sel = 0, bus_data = data_a = 4'b0001.
- Solo B: req_b = 1, data_b = 4'b0110, bus_ready = 1 -> gnt_b and sel = 1 one cycle later, bus_data = 4'b0110. Grant held for 10 beats because no competitor exists.
- Fairness: both req held, bus_ready = 1, HOLD_MAX = 3 -> grant pattern A,A,A,B,B,B,A… and sel toggles every 3 beats with no IDLE cycles.
- Stall: grant A, bus_ready = 0 for 5 cycles with req_b = 1 -> cnt frozen, gnt_a stays 1, bus_data = data_a = 4'b1011 stable. Raising ready then completes the remaining beats before rotation.
- Abort and handover: GNT_A, drop req_a while bus_ready = 0 and req_b = 1 -> next cycle gnt_b = 1, sel = 1, and no A beat is counted.
- Reset mid-grant: in GNT_B with cnt = 2, pulse rst_n = 0 one cycle -> IDLE, sel = 0. With both req, A is granted first after release.

Source files
------------

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner of a WIDTH-bit 2:1 bus mux (F = sel ? B : A) with a
// valid/ready downstream port and a per-grant beat budget for fairness.
module mux_bus_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             bus_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q,  last_d;   // 0 = A owned last, 1 = B owned last
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            sel_q,   sel_d;

  logic            own_req;
  logic            oth_req;
  logic            valid_raw;
  logic            beat;
  logic            budget_done;
  state_e          other_gnt;

  assign gnt_a     = (state_q == GNT_A);
  assign gnt_b     = (state_q == GNT_B);
  assign sel       = sel_q;
  assign valid_raw = (gnt_a & req_a) | (gnt_b & req_b);

  // Reset forces the consumer-facing side quiet and onto input A immediately.
  assign bus_valid = rst_n & valid_raw;
  assign bus_data  = (rst_n & sel_q) ? data_b : data_a;

  assign own_req     = gnt_b ? req_b : req_a;
  assign oth_req     = gnt_b ? req_a : req_b;
  assign beat        = valid_raw & bus_ready;
  assign budget_done = beat & (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    other_gnt = gnt_b ? GNT_A : GNT_B;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_a && (!req_b || last_q)) state_d = GNT_A;
        else if (req_b)                  state_d = GNT_B;
      end
      GNT_A, GNT_B: begin
        // A dropped request and an exhausted budget resolve to one handover.
        if (!own_req || (budget_done && oth_req)) begin
          state_d = oth_req ? other_gnt : IDLE;
          last_d  = gnt_b;
          cnt_d   = '0;
        end else if (budget_done) begin
          cnt_d = '0;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    case (state_d)
      GNT_A:   sel_d = 1'b0;
      GNT_B:   sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

endmodule
